// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serializer
// that chains frames back-to-back while data is queued.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        tx_active,
  output logic                        out_tx,
  output logic                        done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_n;
  logic          wr_ok, pop;

  // Acceptance uses the registered full flag, so a same-cycle pop never frees a slot early.
  assign wr_ok = wr_en & ~full;

  always_comb begin
    count_n = count;
    if (wr_ok && !pop)
      count_n = count + 1'b1;
    else if (!wr_ok && pop)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == DEPTH_C);
      empty <= (count_n == '0);
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    done      = 1'b0;
    out_tx    = 1'b1;
    tx_active = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          timer_n = '0;
          state_n = START;
        end
      end
      START: begin
        out_tx    = 1'b0;
        tx_active = 1'b1;
        if (timer == T_LAST) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        out_tx    = shift[0];
        tx_active = 1'b1;
        if (timer == T_LAST) begin
          timer_n   = '0;
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7)
            state_n = STOP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STOP: begin
        out_tx    = 1'b1;
        tx_active = 1'b1;
        if (timer == T_LAST) begin
          done    = 1'b1;
          timer_n = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line-level frame decoder plus an arithmetic
// model of accept/pop timing predict frames, count, full and overflow.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, tx_active, out_tx, done;
  logic [2:0] count;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_active(tx_active), .out_tx(out_tx), .done(done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int frames_total = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // w = edge that samples the write, p = edge that pops it into the serializer
  typedef struct {logic [7:0] d; int w; int p;} acc_t;
  typedef struct {logic [7:0] d; int s; bit ok;} frm_t;
  acc_t acc[$];
  frm_t exp_q[$];
  frm_t rx_q[$];
  int   last_pop = -100000;
  bit   ovf_m = 1'b0;

  function automatic int cnt_after(input int e);
    int n = 0;
    foreach (acc[i]) if (acc[i].w <= e && acc[i].p > e) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Decode frames from the line: 40 samples, every bit held CPB cycles.
  initial begin : mon
    logic [FRAME-1:0] smp;
    bit   ok, abort;
    int   s;
    frm_t f;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_tx === 1'b0) begin
        s = edge_n; ok = 1'b1; abort = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_n !== 1'b1) abort = 1'b1;
          smp[i] = out_tx;
          if (tx_active !== 1'b1) ok = 1'b0;
          if (done !== (i == FRAME - 1)) ok = 1'b0;
        end
        if (!abort) begin
          for (int b = 0; b < 10; b++)
            for (int j = 1; j < CPB; j++)
              if (smp[b*CPB+j] !== smp[b*CPB]) ok = 1'b0;
          if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) ok = 1'b0;
          for (int b = 0; b < 8; b++) f.d[b] = smp[(b+1)*CPB];
          f.s = s; f.ok = ok;
          rx_q.push_back(f);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    int   w;
    acc_t a;
    frm_t f;
    w = edge_n + 1;
    if (cnt_after(w - 1) >= DEPTH) begin
      ovf_m = 1'b1;
    end else begin
      a.d = d; a.w = w;
      a.p = (w + 1 > last_pop + FRAME) ? w + 1 : last_pop + FRAME;
      last_pop = a.p;
      acc.push_back(a);
      f.d = d; f.s = a.p; f.ok = 1'b1;
      exp_q.push_back(f);
    end
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int   lim = 0;
    frm_t r, e;
    while ((rx_q.size() < exp_q.size() || edge_n < last_pop + FRAME + 2) && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    chk({tag, " timeout"}, lim < 5000, 1);
    chk({tag, " nframes"}, rx_q.size(), exp_q.size());
    frames_total += rx_q.size();
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " data"}, r.d, e.d);
      chk({tag, " start_edge"}, r.s, e.s);
      chk({tag, " frame_shape"}, r.ok, 1);
    end
    rx_q.delete();
    exp_q.delete();
    chk({tag, " done_cnt"}, done_cnt, frames_total);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  p1, guard;
    bit  flag;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    chk("rst out_tx", out_tx, 1);
    chk("rst tx_active", tx_active, 0);
    chk("rst done", done, 0);
    chk("rst full", full, 0);
    chk("rst empty", empty, 1);
    chk("rst count", count, 0);
    chk("rst overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle out_tx", out_tx, 1);

    // Single byte: empty falls after the write edge, line falls one edge later
    push(8'h55);
    chk("single empty", empty, 0);
    chk("single count1", count, cnt_after(edge_n));
    @(negedge clk);
    chk("single count0", count, 0);
    chk("single start", out_tx, 0);
    drain("single");
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_tx !== 1'b1 || tx_active !== 1'b0) flag = 1'b0;
      @(negedge clk);
    end
    chk("single idle after", flag, 1);

    // Back-to-back frames keep tx_active high for three frames
    push(8'hA3); push(8'h0F); push(8'hFF);
    p1 = exp_q[0].s;
    flag = 1'b1;
    while (edge_n < p1 + 3 * FRAME) begin
      if (tx_active !== 1'b1) flag = 1'b0;
      @(negedge clk);
    end
    chk("b2b tx_active", flag, 1);
    chk("b2b idle after", tx_active, 0);
    drain("b2b");

    // Fill and overflow
    for (int i = 0; i < 6; i++) push(8'($urandom));
    chk("fill full", full, cnt_after(edge_n) == DEPTH);
    chk("fill count", count, cnt_after(edge_n));
    chk("fill overflow", overflow, ovf_m);
    drain("fill");
    chk("fill overflow sticky", overflow, 1);

    // Write landing on the STOP-final pop edge with count = 2
    push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
    p1 = exp_q[0].s;
    while (edge_n < p1 + FRAME - 1) @(negedge clk);
    chk("simul count pre", count, 2);
    push(8'($urandom));
    chk("simul count post", count, cnt_after(edge_n));
    chk("simul count2", count, 2);
    drain("simul");

    // Reset during data bit 3
    push(8'($urandom)); push(8'($urandom));
    p1 = exp_q[0].s;
    while (edge_n < p1 + 4 * CPB + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_tx", out_tx, 1);
    chk("midrst tx_active", tx_active, 0);
    chk("midrst empty", empty, 1);
    chk("midrst count", count, 0);
    chk("midrst overflow", overflow, 0);
    acc.delete(); exp_q.delete(); ovf_m = 1'b0; last_pop = -100000;
    repeat (3) @(negedge clk);
    rx_q.delete();
    rst_n = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_tx !== 1'b1 || tx_active !== 1'b0) flag = 1'b0;
    end
    chk("midrst line idle", flag, 1);
    chk("midrst no frames", rx_q.size(), 0);

    // Wrap-around: paced stream keeps count <= 3
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (cnt_after(edge_n) >= 3 && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      b = 8'(i);
      push(b);
    end
    drain("wrap");
    chk("wrap overflow", overflow, 0);

    // Random bytes with random gaps
    for (int i = 0; i < 12; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("rand");
    chk("rand overflow", overflow, ovf_m);
    chk("rand count", count, 0);
    chk("rand empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
